// File: rtl/glay_cache_req_arbiter_if.sv
// Request bus between the request sources, the arbiter and the cache port.
// master = source/sink side, slave = arbiter side.
interface glay_cache_req_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int PAYLOAD_W = 516,
    parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]           req_in_valid;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_in_payload;
    logic [NUM_REQ-1:0]           req_in_ready;
    logic                         req_out_valid;
    logic [PAYLOAD_W-1:0]         req_out_payload;
    logic [ID_W-1:0]              req_out_id;
    logic                         req_out_ready;

    modport master (
        output req_in_valid,
        output req_in_payload,
        input  req_in_ready,
        input  req_out_valid,
        input  req_out_payload,
        input  req_out_id,
        output req_out_ready
    );

    modport slave (
        input  req_in_valid,
        input  req_in_payload,
        output req_in_ready,
        output req_out_valid,
        output req_out_payload,
        output req_out_id,
        input  req_out_ready
    );
endinterface

// File: rtl/glay_cache_req_arbiter.sv
// Round-robin merge of setup-stage and engine requests into one registered cache port.
// Define GLAY_ARB_STATS_EN to add per-source grant counters on grant_count.
module glay_cache_req_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int PAYLOAD_W     = 516,
    parameter int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    glay_cache_req_arbiter_if.slave  bus,
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic                     arb_idle
`ifdef GLAY_ARB_STATS_EN
    ,
    output logic [NUM_REQ*COUNTER_WIDTH-1:0] grant_count
`endif
);

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACTIVE = 2'd1,
        ARB_DRAIN  = 2'd2
    } arb_state_t;

    arb_state_t state_q, state_d;

    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
    logic [ID_W-1:0]      out_id_q, out_id_d;

    logic [NUM_REQ-1:0]   ptr_mask;
    logic [NUM_REQ-1:0]   hi_req;
    logic [NUM_REQ-1:0]   pick_vec;
    logic [NUM_REQ-1:0]   grant;
    logic                 grant_any;
    logic [ID_W-1:0]      grant_idx;
    logic                 load_en;
    logic                 grant_take;
    logic                 out_xfer;
    logic                 any_valid;

    logic [PAYLOAD_W-1:0] pay_arr [NUM_REQ];

    // Per-source views of the flat payload bus, plus the "at or after rr_ptr" mask.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
        assign pay_arr[gi]  = bus.req_in_payload[gi*PAYLOAD_W +: PAYLOAD_W];
        assign ptr_mask[gi] = (ID_W'(gi) >= rr_ptr_q);
        assign grant[gi]    = grant_any && (grant_idx == ID_W'(gi));
    end

    assign any_valid = |bus.req_in_valid;
    assign out_xfer  = out_valid_q && bus.req_out_ready;

    // Round-robin search: lowest valid index at/after rr_ptr, else wrap to lowest valid overall.
    always_comb begin
        hi_req    = bus.req_in_valid & ptr_mask;
        pick_vec  = (|hi_req) ? hi_req : bus.req_in_valid;
        grant_any = any_valid;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pick_vec[k]) begin
                grant_idx = ID_W'(k);
            end
        end
    end

    // FSM: next state and status outputs.
    always_comb begin
        state_d    = state_q;
        load_en    = 1'b0;
        drain_done = 1'b0;
        arb_idle   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (!drain_req && any_valid) begin
                    state_d = ARB_ACTIVE;
                end
            end
            ARB_ACTIVE: begin
                load_en = !out_valid_q || bus.req_out_ready;
                if (drain_req) begin
                    state_d = ARB_DRAIN;
                end else if (!any_valid && !out_xfer) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_DRAIN: begin
                if (!out_valid_q || bus.req_out_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        arb_idle   = (state_q == ARB_IDLE) && !out_valid_q;
        drain_done = arb_idle && drain_req;
    end

    assign grant_take       = load_en && grant_any;
    assign bus.req_in_ready = load_en ? grant : '0;

    // Output register: a new grant overwrites (back-to-back), otherwise consumption empties it.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_payload_d = out_payload_q;
        out_id_d      = out_id_q;
        rr_ptr_d      = rr_ptr_q;

        if (grant_take) begin
            out_valid_d   = 1'b1;
            out_payload_d = pay_arr[grant_idx];
            out_id_d      = grant_idx;
            rr_ptr_d      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_payload_q <= '0;
            out_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            out_valid_q   <= out_valid_d;
            out_payload_q <= out_payload_d;
            out_id_q      <= out_id_d;
        end
    end

    assign bus.req_out_valid   = out_valid_q;
    assign bus.req_out_payload = out_payload_q;
    assign bus.req_out_id      = out_id_q;

`ifdef GLAY_ARB_STATS_EN
    // One free-running, wrapping counter per source; only reset clears it.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [COUNTER_WIDTH-1:0] cnt_q;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                cnt_q <= '0;
            end else if (grant_take && grant[gi]) begin
                cnt_q <= cnt_q + COUNTER_WIDTH'(1);
            end
        end

        assign grant_count[gi*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_q;
    end
`endif

endmodule
